// File: rtl/pacman_motion.sv
// pacman_motion -- per-frame Pac-Man motion engine.
//
// Once per frame_tick_i the engine picks a candidate direction, which is the
// pending request when the turn is aligned and the current direction
// otherwise. It reads the two leading-edge tiles through a 1-cycle-latency
// tile RAM port and commits the stepped position if that path is clear. A
// blocked turn is retried once along the current direction.
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   frame_tick_i       start-of-vblank pulse, starts one evaluation
//   req_valid_i/req_dir_i     direction request (held as pending)
//   load_valid_i/load_*_i     teleport: writes pos/dir, aborts evaluation
//   tile_addr_o/tile_data_i   tile RAM read port (row*80+col, data next cycle)
//   pos_x_o/pos_y_o/dir_o     committed sprite state
//   busy_o             evaluation in progress
//   moved_o            1-cycle pulse on a committed move
//
// Optional feature: define PACMAN_TUNNEL_EN for horizontal wrap-around.
// Direction encoding: 0 up, 1 right, 2 down, 3 left.
module pacman_motion #(
   parameter int STEP       = 1,
   parameter int WALL_TILES = 32,
   parameter int INIT_X     = 336,
   parameter int INIT_Y     = 240,
   parameter int INIT_DIR   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_tick_i,
   input  logic        req_valid_i,
   input  logic [1:0]  req_dir_i,
   input  logic        load_valid_i,
   input  logic [9:0]  load_x_i,
   input  logic [9:0]  load_y_i,
   input  logic [1:0]  load_dir_i,
   output logic [12:0] tile_addr_o,
   input  logic [11:0] tile_data_i,
   output logic [9:0]  pos_x_o,
   output logic [9:0]  pos_y_o,
   output logic [1:0]  dir_o,
   output logic        busy_o,
   output logic        moved_o
);

   typedef enum logic [2:0] {IDLE, RD0, RD1, CHK, COMMIT} state_t;

   localparam logic signed [10:0] STEP_S = 11'(STEP);

   state_t      state_q, state_d;
   logic [9:0]  pos_x_q, pos_y_q, nx_q, ny_q;
   logic [1:0]  dir_q, pend_dir_q, cand_q;
   logic        pend_vld_q, from_pend_q, oob_q, wall_a_q, moved_q, busy_q;
   logic [12:0] tile_addr_q, addr_b_q;

   function automatic logic is_wall(input logic [11:0] id);
      return (id != 12'd0) && (id < 12'(WALL_TILES));
   endfunction

   function automatic logic [12:0] addr_f(input logic [7:0] r, input logic [7:0] c);
      return 13'(r) * 13'd80 + 13'(c);
   endfunction

   // Candidate selection: a same-direction or reversing request never needs
   // alignment; a perpendicular turn needs the cross axis on a tile boundary.
   logic turn_ok, use_pend;
   logic [1:0] sel_dir, ev_dir;
   assign turn_ok  = (pend_dir_q == dir_q) || ((pend_dir_q ^ dir_q) == 2'd2) ||
                     (pend_dir_q[0] ? (pos_y_q[2:0] == 3'd0) : (pos_x_q[2:0] == 3'd0));
   assign use_pend = pend_vld_q && turn_ok;
   assign sel_dir  = use_pend ? pend_dir_q : dir_q;
   // At a tick the candidate is evaluated; on retry (from CHK) the current dir.
   assign ev_dir   = (state_q == IDLE) ? sel_dir : dir_q;

   // Next-position and leading-edge tile computation for ev_dir.
   logic signed [10:0] ex, ey, enx, eny, lead;
   logic [7:0]  col_a, col_b, row_a, row_b;
   logic        ev_oob;

   always_comb begin
      ex  = signed'({1'b0, pos_x_q});
      ey  = signed'({1'b0, pos_y_q});
      enx = ex;
      eny = ey;
      unique case (ev_dir)
         2'd0:    eny = ey - STEP_S;
         2'd1:    enx = ex + STEP_S;
         2'd2:    eny = ey + STEP_S;
         default: enx = ex - STEP_S;
      endcase
`ifdef PACMAN_TUNNEL_EN
      if (ev_dir == 2'd3 && ex < STEP_S) enx = ex + 11'sd640 - STEP_S;
      if (ev_dir == 2'd1 && enx > 11'sd639) enx = enx - 11'sd640;
      ev_oob = (eny < 11'sd0) || (eny > 11'sd464);
`else
      ev_oob = (enx < 11'sd0) || (enx > 11'sd624) ||
               (eny < 11'sd0) || (eny > 11'sd464);
`endif
      unique case (ev_dir)
         2'd0:    lead = eny;
         2'd1:    lead = enx + 11'sd15;
         2'd2:    lead = eny + 11'sd15;
         default: lead = enx;
      endcase
      if (ev_dir[0]) begin
         col_a = 8'(lead >>> 3);
`ifdef PACMAN_TUNNEL_EN
         if (col_a >= 8'd80) col_a = col_a - 8'd80;
`endif
         col_b = col_a;
         row_a = {1'b0, pos_y_q[9:3]};
         row_b = row_a + 8'd1;
      end else begin
         row_a = 8'(lead >>> 3);
         row_b = row_a;
         col_a = {1'b0, pos_x_q[9:3]};
         col_b = col_a + 8'd1;
      end
   end

   // Out-of-range moves still walk RD0/RD1/CHK; the RAM data is masked here.
   logic blocked;
   assign blocked = oob_q || wall_a_q || is_wall(tile_data_i);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (frame_tick_i) state_d = RD0;
         RD0:     state_d = RD1;
         RD1:     state_d = CHK;
         CHK: begin
            if (!blocked)              state_d = COMMIT;
            else if (cand_q != dir_q)  state_d = RD0;
            else                       state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (load_valid_i) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         pos_x_q     <= 10'(INIT_X);
         pos_y_q     <= 10'(INIT_Y);
         dir_q       <= 2'(INIT_DIR);
         pend_vld_q  <= 1'b0;
         pend_dir_q  <= 2'd0;
         cand_q      <= 2'd0;
         from_pend_q <= 1'b0;
         nx_q        <= 10'd0;
         ny_q        <= 10'd0;
         oob_q       <= 1'b0;
         wall_a_q    <= 1'b0;
         addr_b_q    <= 13'd0;
         tile_addr_q <= 13'd0;
         moved_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         moved_q <= 1'b0;
         busy_q  <= (state_d != IDLE);
         if (state_d == RD0 && (state_q == IDLE || state_q == CHK)) begin
            cand_q      <= ev_dir;
            from_pend_q <= (state_q == IDLE) && use_pend;
            nx_q        <= enx[9:0];
            ny_q        <= eny[9:0];
            oob_q       <= ev_oob;
            tile_addr_q <= addr_f(row_a, col_a);
            addr_b_q    <= addr_f(row_b, col_b);
         end
         if (state_q == RD0) tile_addr_q <= addr_b_q;
         if (state_q == RD1) wall_a_q <= is_wall(tile_data_i);
         if (state_q == CHK && state_d == COMMIT) begin
            pos_x_q <= nx_q;
            pos_y_q <= ny_q;
            dir_q   <= cand_q;
            moved_q <= 1'b1;
            if (from_pend_q) pend_vld_q <= 1'b0;
         end
         // A fresh request overrides the commit-clear; a teleport overrides both.
         if (req_valid_i) begin
            pend_vld_q <= 1'b1;
            pend_dir_q <= req_dir_i;
         end
         if (load_valid_i) begin
            pos_x_q    <= load_x_i;
            pos_y_q    <= load_y_i;
            dir_q      <= load_dir_i;
            pend_vld_q <= 1'b0;
         end
      end
   end

   assign tile_addr_o = tile_addr_q;
   assign pos_x_o     = pos_x_q;
   assign pos_y_o     = pos_y_q;
   assign dir_o       = dir_q;
   assign busy_o      = busy_q;
   assign moved_o     = moved_q;

endmodule

// File: tb/tb_pacman_motion.sv
// Directed testbench for pacman_motion. Tile RAM is a 1-cycle-latency model.
module tb_pacman_motion;
   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick, req_valid, load_valid;
   logic [1:0]  req_dir, load_dir, dir;
   logic [9:0]  load_x, load_y, pos_x, pos_y;
   logic [12:0] tile_addr;
   logic [11:0] tile_data;
   logic        busy, moved;

   int checks = 0;
   int failures = 0;

   logic [11:0] tmap [0:8191];

   always #10 clk = ~clk;

   always @(posedge clk) tile_data <= tmap[tile_addr];

   pacman_motion dut (
      .clk(clk), .reset(reset),
      .frame_tick_i(frame_tick), .req_valid_i(req_valid), .req_dir_i(req_dir),
      .load_valid_i(load_valid), .load_x_i(load_x), .load_y_i(load_y), .load_dir_i(load_dir),
      .tile_addr_o(tile_addr), .tile_data_i(tile_data),
      .pos_x_o(pos_x), .pos_y_o(pos_y), .dir_o(dir), .busy_o(busy), .moved_o(moved)
   );

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic tick();
      @(negedge clk) frame_tick = 1'b1;
      @(negedge clk) frame_tick = 1'b0;
   endtask

   task automatic req(input logic [1:0] d);
      @(negedge clk) begin req_valid = 1'b1; req_dir = d; end
      @(negedge clk) req_valid = 1'b0;
   endtask

   task automatic load(input int x, input int y, input int d);
      @(negedge clk) begin
         load_valid = 1'b1; load_x = 10'(x); load_y = 10'(y); load_dir = 2'(d);
      end
      @(negedge clk) load_valid = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (pos_x !== 10'd336) begin failures++; $display("FAIL reset_x got %0d exp 336", pos_x); end
      checks++; if (pos_y !== 10'd240) begin failures++; $display("FAIL reset_y got %0d exp 240", pos_y); end
      checks++; if (dir !== 2'd1) begin failures++; $display("FAIL reset_dir got %0d exp 1", dir); end
      checks++; if ({busy, moved} !== 2'b00) begin failures++; $display("FAIL reset_flags got %b exp 00", {busy, moved}); end
      checks++; if (tile_addr !== 13'd0) begin failures++; $display("FAIL reset_addr got %0d exp 0", tile_addr); end
   endtask

   task automatic test_basic_move();
      tick();                                   // T+1
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b exp 1", busy); end
      checks++; if (tile_addr !== 13'd2444) begin failures++; $display("FAIL basic_addr_a got %0d exp 2444", tile_addr); end
      nxt();                                    // T+2
      checks++; if (tile_addr !== 13'd2524) begin failures++; $display("FAIL basic_addr_b got %0d exp 2524", tile_addr); end
      frame_tick = 1'b1;                        // tick while busy: ignored
      nxt();                                    // T+3
      frame_tick = 1'b0;
      checks++; if (moved !== 1'b0) begin failures++; $display("FAIL basic_early_moved got %b exp 0", moved); end
      nxt();                                    // T+4
      checks++; if ({moved, busy} !== 2'b11) begin failures++; $display("FAIL basic_commit_flags got %b exp 11", {moved, busy}); end
      checks++; if (pos_x !== 10'd337 || pos_y !== 10'd240 || dir !== 2'd1) begin
         failures++; $display("FAIL basic_commit_pos got (%0d,%0d,%0d) exp (337,240,1)", pos_x, pos_y, dir); end
      nxt();
      checks++; if ({moved, busy} !== 2'b00) begin failures++; $display("FAIL basic_after_flags got %b exp 00", {moved, busy}); end
      repeat (6) nxt();
      checks++; if (pos_x !== 10'd337) begin failures++; $display("FAIL busy_tick_ignored got %0d exp 337", pos_x); end
   endtask

   task automatic test_wall_blocked();
      int seen;
      load(336, 240, 1);
      tmap[2444] = 12'd5;
      tick();
      seen = 0;
      nxt(); nxt();                             // T+3
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wall_chk_busy got %b exp 1", busy); end
      nxt();                                    // T+4
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wall_busy_end got %b exp 0", busy); end
      repeat (3) begin if (moved) seen = 1; nxt(); end
      checks++; if (seen != 0 || pos_x !== 10'd336 || dir !== 2'd1) begin
         failures++; $display("FAIL wall_blocked got x=%0d dir=%0d moved=%0d exp x=336 dir=1 moved=0", pos_x, dir, seen); end
      tmap[2444] = 12'd32;                      // id == WALL_TILES is passable
      tick(); repeat (3) nxt();
      checks++; if (pos_x !== 10'd337 || moved !== 1'b1) begin
         failures++; $display("FAIL wall_id_limit got x=%0d moved=%b exp 337 1", pos_x, moved); end
      tmap[2444] = 12'd0;
      nxt();
   endtask

   task automatic test_unaligned_turn();
      load(343, 240, 1);
      req(2'd0);
      tick(); repeat (3) nxt();
      checks++; if (pos_x !== 10'd344 || pos_y !== 10'd240 || dir !== 2'd1) begin
         failures++; $display("FAIL unaligned_move got (%0d,%0d,%0d) exp (344,240,1)", pos_x, pos_y, dir); end
      nxt();
      tick();
      checks++; if (tile_addr !== 13'd2363) begin failures++; $display("FAIL turn_up_addr got %0d exp 2363", tile_addr); end
      repeat (3) nxt();
      checks++; if (pos_x !== 10'd344 || pos_y !== 10'd239 || dir !== 2'd0) begin
         failures++; $display("FAIL pending_turn got (%0d,%0d,%0d) exp (344,239,0)", pos_x, pos_y, dir); end
      nxt();
   endtask

   task automatic test_retry();
      load(336, 240, 1);
      tmap[2602] = 12'd7; tmap[2603] = 12'd7;
      req(2'd2);
      tick(); nxt(); nxt(); nxt();              // T+4: back in RD0 for retry
      checks++; if (busy !== 1'b1 || moved !== 1'b0 || tile_addr !== 13'd2444) begin
         failures++; $display("FAIL retry_rd0 got busy=%b moved=%b addr=%0d exp 1 0 2444", busy, moved, tile_addr); end
      nxt(); nxt();                             // T+6
      checks++; if (moved !== 1'b0) begin failures++; $display("FAIL retry_early got %b exp 0", moved); end
      nxt();                                    // T+7
      checks++; if (moved !== 1'b1 || pos_x !== 10'd337 || pos_y !== 10'd240 || dir !== 2'd1) begin
         failures++; $display("FAIL retry_commit got m=%b (%0d,%0d,%0d) exp 1 (337,240,1)", moved, pos_x, pos_y, dir); end
      nxt();
      tmap[2602] = 12'd0; tmap[2603] = 12'd0;
      // Pending down survives seven right moves and fires once x reaches 344.
      for (int i = 0; i < 8; i++) begin tick(); repeat (4) nxt(); end
      checks++; if (pos_x !== 10'd344 || pos_y !== 10'd241 || dir !== 2'd2) begin
         failures++; $display("FAIL retry_pending_kept got (%0d,%0d,%0d) exp (344,241,2)", pos_x, pos_y, dir); end
   endtask

   task automatic test_load_abort();
      int seen;
      @(negedge clk) begin
         frame_tick = 1'b1; load_valid = 1'b1; load_x = 10'd100; load_y = 10'd200; load_dir = 2'd2;
      end
      @(negedge clk) begin frame_tick = 1'b0; load_valid = 1'b0; end
      checks++; if (pos_x !== 10'd100 || pos_y !== 10'd200 || dir !== 2'd2 || busy !== 1'b0) begin
         failures++; $display("FAIL load_vs_tick got (%0d,%0d,%0d) busy=%b exp (100,200,2) 0", pos_x, pos_y, dir, busy); end
      seen = 0;
      repeat (4) begin nxt(); if (moved) seen = 1; end
      checks++; if (seen != 0 || pos_y !== 10'd200) begin failures++; $display("FAIL load_tick_dropped got y=%0d moved=%0d exp 200 0", pos_y, seen); end
      tick(); nxt();                            // T+2
      load_valid = 1'b1; load_x = 10'd50; load_y = 10'd60; load_dir = 2'd1;
      nxt();
      load_valid = 1'b0;
      checks++; if (busy !== 1'b0 || pos_x !== 10'd50 || pos_y !== 10'd60 || dir !== 2'd1) begin
         failures++; $display("FAIL load_abort got busy=%b (%0d,%0d,%0d) exp 0 (50,60,1)", busy, pos_x, pos_y, dir); end
      seen = 0;
      repeat (5) begin nxt(); if (moved) seen = 1; end
      checks++; if (seen != 0 || pos_x !== 10'd50) begin failures++; $display("FAIL load_no_commit got x=%0d moved=%0d exp 50 0", pos_x, seen); end
   endtask

   task automatic test_bounds();
      int seen;
      load(336, 0, 0);
      tick(); seen = 0;
      repeat (4) begin nxt(); if (moved) seen = 1; end
      checks++; if (seen != 0 || pos_y !== 10'd0) begin failures++; $display("FAIL bound_top got y=%0d moved=%0d exp 0 0", pos_y, seen); end
      load(336, 464, 2);
      tick(); seen = 0;
      repeat (4) begin nxt(); if (moved) seen = 1; end
      checks++; if (seen != 0 || pos_y !== 10'd464) begin failures++; $display("FAIL bound_bottom got y=%0d moved=%0d exp 464 0", pos_y, seen); end
      load(624, 240, 1);
      tick(); repeat (4) nxt();
`ifdef PACMAN_TUNNEL_EN
      checks++; if (pos_x !== 10'd625) begin failures++; $display("FAIL bound_right got %0d exp 625", pos_x); end
`else
      checks++; if (pos_x !== 10'd624) begin failures++; $display("FAIL bound_right got %0d exp 624", pos_x); end
`endif
   endtask

   task automatic test_tunnel();
      int seen;
      load(0, 240, 3);
      tick();
`ifdef PACMAN_TUNNEL_EN
      checks++; if (tile_addr !== 13'd2479) begin failures++; $display("FAIL tunnel_addr got %0d exp 2479", tile_addr); end
      repeat (3) nxt();
      checks++; if (pos_x !== 10'd639 || moved !== 1'b1 || dir !== 2'd3) begin
         failures++; $display("FAIL tunnel_wrap got x=%0d m=%b d=%0d exp 639 1 3", pos_x, moved, dir); end
`else
      seen = 0;
      repeat (4) begin nxt(); if (moved) seen = 1; end
      checks++; if (seen != 0 || pos_x !== 10'd0) begin failures++; $display("FAIL tunnel_off got x=%0d moved=%0d exp 0 0", pos_x, seen); end
`endif
      nxt();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8192; i++) tmap[i] = 12'd0;
      reset = 1'b1; frame_tick = 1'b0; req_valid = 1'b0; req_dir = 2'd0;
      load_valid = 1'b0; load_x = 10'd0; load_y = 10'd0; load_dir = 2'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      nxt();
      test_reset();
      test_basic_move();
      test_wall_blocked();
      test_unaligned_turn();
      test_retry();
      test_load_abort();
      test_bounds();
      test_tunnel();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
